// File: rtl/rf_pkg.sv
// Shared definitions for the reg_f write-back scheduler.
//   ADDR_WIDTH_DEF / WIDTH_DEF : default address / data widths
//   wb_gnt_t                   : identifies the last write-back requester granted
//   REG_ZERO                   : hardwired-zero register index
package rf_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned NUM_REGS_DEF   = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic {GNT_ALU, GNT_LSU} wb_gnt_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_wb_sched_if.sv
// Bundle of issue, ALU/LSU write-back and reg_f write-port signals.
//   master : decode/issue + execution units + reg_f side (drives requests)
//   slave  : rf_wb_sched side (drives stall, readies, write port, scoreboard)
interface rf_wb_sched_if #(
  parameter int unsigned ADDR_WIDTH = rf_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned WIDTH      = rf_pkg::WIDTH_DEF
) ();

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  iss_valid;
  logic                  iss_we;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [ADDR_WIDTH-1:0] iss_rs1;
  logic [ADDR_WIDTH-1:0] iss_rs2;
  logic                  iss_stall;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [WIDTH-1:0]      lsu_data;
  logic                  lsu_ready;

  logic                  rwb_we;
  logic [ADDR_WIDTH-1:0] rwb_addr;
  logic [WIDTH-1:0]      rwb_data;
  logic [NUM_REGS-1:0]   busy_vec;
  logic                  wb_err;

  modport master (
    output iss_valid, iss_we, iss_rd, iss_rs1, iss_rs2,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_stall, alu_ready, lsu_ready,
    input  rwb_we, rwb_addr, rwb_data, busy_vec, wb_err
  );

  modport slave (
    input  iss_valid, iss_we, iss_rd, iss_rs1, iss_rs2,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_stall, alu_ready, lsu_ready,
    output rwb_we, rwb_addr, rwb_data, busy_vec, wb_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, one grant per cycle.
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : bit 0 = ALU, bit 1 = LSU
//   gnt[1:0] : one-hot grant (combinational), zero while in reset
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_gnt_t last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (!rst) begin
      if (req == 2'b11) begin
        // Tie: favour whoever was not granted most recently.
        gnt = (last_q == GNT_LSU) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
      if (gnt[0]) begin
        last_d = GNT_ALU;
      end else if (gnt[1]) begin
        last_d = GNT_LSU;
      end
    end
  end

  // Reset to LSU so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and scoreboard for reg_f's single write port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : issue request/stall, ALU and LSU write-back handshakes,
//              registered reg_f write port, busy scoreboard and sticky wb_err
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  rf_wb_sched_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RegZero = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  rwb_we_q, rwb_we_d;
  logic [ADDR_WIDTH-1:0] rwb_addr_q, rwb_addr_d;
  logic [WIDTH-1:0]      rwb_data_q, rwb_data_d;
  logic                  wb_err_q, wb_err_d;

  logic [1:0]            gnt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [WIDTH-1:0]      wb_data;
  logic                  iss_stall;
  logic                  iss_accept;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.lsu_valid, bus.alu_valid}),
    .gnt (gnt)
  );

  // Grants only exist for valid requesters, so any grant is a transfer.
  assign xfer    = |gnt;
  assign wb_rd   = gnt[1] ? bus.lsu_rd   : bus.alu_rd;
  assign wb_data = gnt[1] ? bus.lsu_data : bus.alu_data;

  // No bypass: busy stays set through the rwb_we cycle, so dependents wait.
  assign iss_stall = rst | (bus.iss_valid & (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] |
                                             (bus.iss_we & busy_q[bus.iss_rd])));
  assign iss_accept = bus.iss_valid & ~iss_stall;

  always_comb begin
    busy_d = busy_q;
    if (rwb_we_q) begin
      busy_d[rwb_addr_q] = 1'b0;
    end
    // Set after clear so a same-register collision leaves the bit set.
    if (iss_accept && bus.iss_we && (bus.iss_rd != RegZero)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_comb begin
    rwb_we_d   = 1'b0;
    rwb_addr_d = rwb_addr_q;
    rwb_data_d = rwb_data_q;
    wb_err_d   = wb_err_q;
    if (xfer) begin
      // Writes to x0 complete the handshake but never reach reg_f.
      rwb_we_d   = (wb_rd != RegZero);
      rwb_addr_d = wb_rd;
      rwb_data_d = wb_data;
      if ((wb_rd != RegZero) && !busy_q[wb_rd]) begin
        wb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rwb_we_q   <= 1'b0;
      rwb_addr_q <= '0;
      rwb_data_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rwb_we_q   <= rwb_we_d;
      rwb_addr_q <= rwb_addr_d;
      rwb_data_q <= rwb_data_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign bus.iss_stall = iss_stall;
  assign bus.alu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];
  assign bus.rwb_we    = rwb_we_q;
  assign bus.rwb_addr  = rwb_addr_q;
  assign bus.rwb_data  = rwb_data_q;
  assign bus.busy_vec  = busy_q;
  assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
module tb_rf_wb_sched;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_wb_sched_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

  rf_wb_sched #(.ADDR_WIDTH(AW), .WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iss_valid = 1'b0; bus.iss_we = 1'b0;
    bus.iss_rd = '0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.iss_valid = 1'b1; bus.iss_we = 1'b1; bus.iss_rd = rd;
    bus.iss_rs1 = '0; bus.iss_rs2 = '0;
    tick();
    bus.iss_valid = 1'b0; bus.iss_we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 8'h11;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.alu_ready !== 1'b0) begin
        $display("FAIL reset_alu_ready cyc%0d: got %b want 0", i, bus.alu_ready); errors++;
      end
      checks++;
      if (bus.iss_stall !== 1'b1) begin
        $display("FAIL reset_stall cyc%0d: got %b want 1", i, bus.iss_stall); errors++;
      end
    end
    bus.alu_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy_vec !== 16'h0000) begin
      $display("FAIL reset_busy: got %h want 0000", bus.busy_vec); errors++;
    end
    checks++;
    if (bus.rwb_we !== 1'b0 || bus.rwb_addr !== 4'd0 || bus.rwb_data !== 8'h00) begin
      $display("FAIL reset_rwb: got we=%b a=%h d=%h want 0/0/00",
               bus.rwb_we, bus.rwb_addr, bus.rwb_data); errors++;
    end
    checks++;
    if (bus.wb_err !== 1'b0) begin
      $display("FAIL reset_wb_err: got %b want 0", bus.wb_err); errors++;
    end
  endtask

  task automatic test_raw();
    issue(4'd3);
    checks++;
    if (bus.busy_vec !== 16'h0008) begin
      $display("FAIL raw_busy_set: got %h want 0008", bus.busy_vec); errors++;
    end
    bus.iss_valid = 1'b1; bus.iss_we = 1'b0; bus.iss_rs1 = 4'd3;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b1) begin
      $display("FAIL raw_stall: got %b want 1", bus.iss_stall); errors++;
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd3; bus.alu_data = 8'h2A;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      $display("FAIL raw_alu_ready: got %b want 1", bus.alu_ready); errors++;
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rwb_we !== 1'b1 || bus.rwb_addr !== 4'd3 || bus.rwb_data !== 8'h2A) begin
      $display("FAIL raw_rwb: got we=%b a=%h d=%h want 1/3/2a",
               bus.rwb_we, bus.rwb_addr, bus.rwb_data); errors++;
    end
    checks++;
    if (bus.iss_stall !== 1'b1) begin
      $display("FAIL raw_no_bypass_stall: got %b want 1", bus.iss_stall); errors++;
    end
    tick();
    checks++;
    if (bus.busy_vec !== 16'h0000 || bus.iss_stall !== 1'b0) begin
      $display("FAIL raw_clear: got busy=%h stall=%b want 0000/0",
               bus.busy_vec, bus.iss_stall); errors++;
    end
    checks++;
    if (bus.rwb_we !== 1'b0 || bus.rwb_addr !== 4'd3 || bus.rwb_data !== 8'h2A) begin
      $display("FAIL raw_rwb_hold: got we=%b a=%h d=%h want 0/3/2a",
               bus.rwb_we, bus.rwb_addr, bus.rwb_data); errors++;
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    do_reset();
    issue(4'd1);
    issue(4'd2);
    checks++;
    if (bus.busy_vec !== 16'h0006) begin
      $display("FAIL cont_busy: got %h want 0006", bus.busy_vec); errors++;
    end
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_data = 8'd10;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 4'd2; bus.lsu_data = 8'd20;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
      $display("FAIL cont_first_gnt: got alu=%b lsu=%b want 1/0",
               bus.alu_ready, bus.lsu_ready); errors++;
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      $display("FAIL cont_second_gnt: got lsu=%b want 1", bus.lsu_ready); errors++;
    end
    checks++;
    if (bus.rwb_we !== 1'b1 || bus.rwb_addr !== 4'd1 || bus.rwb_data !== 8'd10) begin
      $display("FAIL cont_rwb1: got we=%b a=%h d=%h want 1/1/0a",
               bus.rwb_we, bus.rwb_addr, bus.rwb_data); errors++;
    end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rwb_we !== 1'b1 || bus.rwb_addr !== 4'd2 || bus.rwb_data !== 8'd20) begin
      $display("FAIL cont_rwb2: got we=%b a=%h d=%h want 1/2/14",
               bus.rwb_we, bus.rwb_addr, bus.rwb_data); errors++;
    end
    checks++;
    if (bus.busy_vec !== 16'h0004) begin
      $display("FAIL cont_busy_mid: got %h want 0004", bus.busy_vec); errors++;
    end
    tick();
    checks++;
    if (bus.busy_vec !== 16'h0000 || bus.rwb_we !== 1'b0 || bus.wb_err !== 1'b0) begin
      $display("FAIL cont_done: got busy=%h we=%b err=%b want 0000/0/0",
               bus.busy_vec, bus.rwb_we, bus.wb_err); errors++;
    end
  endtask

  // Last grant was LSU, so the sequence starts with the ALU.
  task automatic test_round_robin();
    logic [AW-1:0] alu_rds [2];
    logic [AW-1:0] lsu_rds [2];
    logic [AW-1:0] exp_addr [4];
    int ai;
    int li;
    alu_rds  = '{4'd4, 4'd6};
    lsu_rds  = '{4'd5, 4'd7};
    exp_addr = '{4'd4, 4'd5, 4'd6, 4'd7};
    for (int r = 4; r < 8; r++) issue(4'(r));
    ai = 0; li = 0;
    bus.alu_valid = 1'b1; bus.alu_rd = alu_rds[0]; bus.alu_data = 8'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = lsu_rds[0]; bus.lsu_data = 8'hB0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.alu_ready !== ((k % 2) == 0) || bus.lsu_ready !== ((k % 2) == 1)) begin
        $display("FAIL rr_gnt%0d: got alu=%b lsu=%b want %0d/%0d",
                 k, bus.alu_ready, bus.lsu_ready, (k % 2) == 0, (k % 2) == 1); errors++;
      end
      tick();
      if ((k % 2) == 0) begin
        ai++;
        if (ai < 2) begin
          bus.alu_rd = alu_rds[ai]; bus.alu_data = 8'hA1;
        end else bus.alu_valid = 1'b0;
      end else begin
        li++;
        if (li < 2) begin
          bus.lsu_rd = lsu_rds[li]; bus.lsu_data = 8'hB1;
        end else bus.lsu_valid = 1'b0;
      end
      #1;
      checks++;
      if (bus.rwb_we !== 1'b1 || bus.rwb_addr !== exp_addr[k]) begin
        $display("FAIL rr_rwb%0d: got we=%b a=%h want 1/%h",
                 k, bus.rwb_we, bus.rwb_addr, exp_addr[k]); errors++;
      end
    end
    tick();
    checks++;
    if (bus.busy_vec !== 16'h0000 || bus.wb_err !== 1'b0) begin
      $display("FAIL rr_done: got busy=%h err=%b want 0000/0", bus.busy_vec, bus.wb_err);
      errors++;
    end
  endtask

  task automatic test_x0();
    bus.iss_valid = 1'b1; bus.iss_we = 1'b1; bus.iss_rd = 4'd0;
    #1;
    checks++;
    if (bus.iss_stall !== 1'b0) begin
      $display("FAIL x0_stall: got %b want 0", bus.iss_stall); errors++;
    end
    tick();
    bus.iss_valid = 1'b0; bus.iss_we = 1'b0;
    #1;
    checks++;
    if (bus.busy_vec !== 16'h0000) begin
      $display("FAIL x0_busy: got %h want 0000", bus.busy_vec); errors++;
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 4'd0; bus.lsu_data = 8'h77;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      $display("FAIL x0_lsu_ready: got %b want 1", bus.lsu_ready); errors++;
    end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rwb_we !== 1'b0 || bus.wb_err !== 1'b0) begin
      $display("FAIL x0_wb: got we=%b err=%b want 0/0", bus.rwb_we, bus.wb_err); errors++;
    end
  endtask

  task automatic test_err_reset();
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd5; bus.alu_data = 8'h55;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      $display("FAIL err_alu_ready: got %b want 1", bus.alu_ready); errors++;
    end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++;
    if (bus.rwb_we !== 1'b1 || bus.rwb_addr !== 4'd5 || bus.rwb_data !== 8'h55 ||
        bus.wb_err !== 1'b1) begin
      $display("FAIL err_set: got we=%b a=%h d=%h err=%b want 1/5/55/1",
               bus.rwb_we, bus.rwb_addr, bus.rwb_data, bus.wb_err); errors++;
    end
    tick();
    tick();
    checks++;
    if (bus.wb_err !== 1'b1 || bus.busy_vec !== 16'h0000) begin
      $display("FAIL err_sticky: got err=%b busy=%h want 1/0000", bus.wb_err, bus.busy_vec);
      errors++;
    end
    issue(4'd7);
    checks++;
    if (bus.busy_vec !== 16'h0080) begin
      $display("FAIL err_busy7: got %h want 0080", bus.busy_vec); errors++;
    end
    rst = 1'b1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 4'd7; bus.lsu_data = 8'h99;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b0 || bus.iss_stall !== 1'b1) begin
      $display("FAIL rst_comb: got lsu_ready=%b stall=%b want 0/1",
               bus.lsu_ready, bus.iss_stall); errors++;
    end
    tick();
    checks++;
    if (bus.busy_vec !== 16'h0000 || bus.wb_err !== 1'b0 || bus.rwb_we !== 1'b0 ||
        bus.lsu_ready !== 1'b0) begin
      $display("FAIL rst_state: got busy=%h err=%b we=%b lsu_ready=%b want 0000/0/0/0",
               bus.busy_vec, bus.wb_err, bus.rwb_we, bus.lsu_ready); errors++;
    end
    bus.lsu_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.rwb_we !== 1'b0 || bus.busy_vec !== 16'h0000) begin
      $display("FAIL rst_after: got we=%b busy=%h want 0/0000", bus.rwb_we, bus.busy_vec);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_raw();
    test_contention();
    test_round_robin();
    test_x0();
    test_err_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
Write-back scheduler and scoreboard for reg_f's single write port. Arbitrates round-robin between ALU and LSU write-back requesters and drives rwb_we/rwb_addr/rwb_data. Tracks one busy bit per architectural register and stalls issue on RAW and WAW hazards. Sits between decode/issue, the execution units and reg_f.

Parameters:
ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH
WIDTH, 8, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
iss_valid  in  1  decode presents an instruction
iss_we  in  1  instruction writes rd
iss_rd  in  ADDR_WIDTH  destination register
iss_rs1  in  ADDR_WIDTH  source 1
iss_rs2  in  ADDR_WIDTH  source 2
iss_stall  out  1  combinational; issue must hold
alu_valid  in  1  ALU write-back request
alu_rd  in  ADDR_WIDTH  ALU destination
alu_data  in  WIDTH  ALU result
alu_ready  out  1  combinational; ALU request granted this cycle
lsu_valid  in  1  LSU write-back request
lsu_rd  in  ADDR_WIDTH  LSU destination
lsu_data  in  WIDTH  load result
lsu_ready  out  1  combinational; LSU request granted this cycle
rwb_we  out  1  registered write enable to reg_f
rwb_addr  out  ADDR_WIDTH  registered write address
rwb_data  out  WIDTH  registered write data
busy_vec  out  NUM_REGS  registered scoreboard bits
wb_err  out  1  sticky: write-back to a non-busy register

Behaviour:
- Reset (rst=1 at an edge): busy_vec=0, rwb_we=0, rwb_addr=0, rwb_data=0, wb_err=0, last_grant=LSU, so ALU wins the first tie. While rst=1: alu_ready=lsu_ready=0 and iss_stall=1. Reset mid-operation discards in-flight grants and all busy bits.
- Register 0 is hardwired zero. It is never marked busy and never causes a stall. A granted write-back with rd=0 completes its handshake (ready=1) but produces rwb_we=0 and does not set wb_err.
- iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_we & busy[iss_rd])).
- Issue is accepted when iss_valid & !iss_stall. If iss_we and iss_rd!=0, busy[iss_rd] is set at that edge.
- Arbitration, one grant per cycle:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to the requester not in last_grant. last_grant updates only on a grant.
  - ready = grant. A transfer occurs when valid & ready at the edge.
  - A requester holds valid/rd/data stable until ready; requesters must not drop valid before ready.
- Write-back latency is 1 cycle. A transfer at edge N gives rwb_we=1 with rwb_addr=rd and rwb_data=data for the cycle after N. reg_f commits at the following edge N+1.
- busy[rwb_addr] clears at the same edge where reg_f commits (the end of the rwb_we=1 cycle). An issue in the next cycle sees busy=0 and reads the committed value.
- No bypass: during the rwb_we=1 cycle, busy is still 1, so dependent issue stalls that cycle.
- Set and clear of the same register at one edge cannot occur, because WAW stall prevents it. If forced, set wins.
- Transfer to rd!=0 with busy[rd]=0: the write is still performed, busy is unaffected, and wb_err sets. wb_err stays high until rst.
- No transfer in a cycle: rwb_we=0 next cycle; rwb_addr and rwb_data hold their last values.

Decomposition:
- Package rf_pkg:
  - ADDR_WIDTH/WIDTH defaults and NUM_REGS
  - typedef enum logic {GNT_ALU, GNT_LSU} wb_gnt_t
  - constant REG_ZERO = 0
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs req[1:0], clk, rst. Output one-hot gnt. Holds the last_grant register.
- Scoreboard, stall logic and write-back register stay in rf_wb_sched.

Test Plan:
1. Reset: hold rst 2 cycles with alu_valid=1 -> alu_ready=0 and iss_stall=1 throughout; after reset busy_vec=0, rwb_we=0, wb_err=0.
2. RAW path:
   - Issue rd=3 we=1 -> busy_vec[3]=1 next cycle.
   - Issue rs1=3 -> iss_stall=1.
   - alu_valid rd=3 data=8'h2A -> alu_ready=1; next cycle rwb_we=1 addr=3 data=8'h2A, stall still 1.
   - Following cycle busy_vec[3]=0 and stall=0.
3. Contention: issue rd=1 and rd=2, then assert alu(rd=1,data=10) and lsu(rd=2,data=20) together -> ALU granted first, LSU next cycle; rwb sequence (1,10),(2,20); busy_vec returns to 0.
4. Round-robin: hold both alu and lsu valid for 4 transfers -> grants alternate ALU,LSU,ALU,LSU.
5. x0: issue rd=0 we=1 -> busy_vec stays 0, no stall. lsu write-back rd=0 -> lsu_ready=1, rwb_we=0, wb_err=0.
6. Error and reset:
   - ALU write-back to non-busy rd=5 data=8'h55 -> rwb written, wb_err=1 and stays 1.
   - Later, rst with busy_vec[7]=1 and lsu_valid=1 -> busy_vec=0, wb_err=0, rwb_we=0, lsu_ready=0 during rst.
